// File: rtl/mac_layer_engine.sv
// Systolic MAC chain: N_MACS lanes with per-lane weights. The operand enters
// slot 0 and moves one lane per cycle. LOAD passes take an external stream.
// LAYER passes re-feed the previous results, clamped to W bits.
module mac_layer_engine #(
    parameter int W      = 8,
    parameter int ACC_W  = 16,
    parameter int N_MACS = 4,
    parameter int K_MAX  = 16,
    parameter int SAT    = 1,
    localparam int LEN_W = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [LEN_W-1:0]        len,
    input  logic                    clear_all,
    input  logic [W-1:0]            a_in,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [N_MACS*W-1:0]     w_in,
    output logic                    busy,
    output logic                    done,
    output logic [N_MACS*ACC_W-1:0] acc_out,
    output logic [N_MACS-1:0]       valid_out
);
    localparam int CNT_W = $clog2(K_MAX + N_MACS + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FEED = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t                  state_reg;
    logic                    mode_reg;
    logic [LEN_W-1:0]        len_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    a_ready_reg, busy_reg, done_reg;

    logic signed [W-1:0]     w_reg  [N_MACS];
    logic signed [W-1:0]     h_reg  [N_MACS];
    logic signed [W-1:0]     h_next [N_MACS];
    logic signed [W-1:0]     op_reg [N_MACS];
    logic signed [W-1:0]     op_in  [N_MACS];
    logic [N_MACS-1:0]       vld_reg, first_reg, last_reg, valid_reg;
    logic [N_MACS-1:0]       vld_in, first_in, last_in;
    logic signed [ACC_W-1:0] acc_reg [N_MACS];

    logic                    start_acc, feed_fire, feed_first, feed_last;
    logic signed [W-1:0]     feed_op;

    // Two's-complement overflow shows up as disagreeing top bits of the wide sum
    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
        if (SAT != 0 && s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    // Clamp an accumulator to the operand range for layer chaining
    function automatic logic [W-1:0] clamp_w(input logic [ACC_W-1:0] a);
        logic [ACC_W-W:0] top;
        top = a[ACC_W-1:W-1];
        if (&top || ~|top)
            return a[W-1:0];
        return a[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    // A start is taken only from IDLE, and clear_all overrides it
    assign start_acc = start && !clear_all && (state_reg == S_IDLE);

    // Operand source and first/last tagging for the sample entering slot 0
    always_comb begin
        feed_fire  = (state_reg == S_FEED) && (mode_reg || (a_valid && a_ready_reg));
        feed_op    = mode_reg ? h_reg[0] : $signed(a_in);
        feed_first = (cnt_reg == '0);
        feed_last  = ((cnt_reg + CNT_W'(1)) ==
                      (mode_reg ? CNT_W'(N_MACS) : CNT_W'(len_reg)));
    end

    // Pass control: IDLE -> FEED -> DRAIN -> IDLE, done on final lane result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            mode_reg    <= 1'b0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            a_ready_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (clear_all) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            a_ready_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_acc) begin
                        mode_reg <= mode;
                        len_reg  <= len;
                        cnt_reg  <= '0;
                        if (!mode && len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg   <= S_FEED;
                            busy_reg    <= 1'b1;
                            a_ready_reg <= !mode;
                        end
                    end
                end
                S_FEED: begin
                    if (feed_fire) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (feed_last) begin
                            state_reg   <= S_DRAIN;
                            a_ready_reg <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (vld_reg[N_MACS-1] && last_reg[N_MACS-1]) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_MACS; gi++) begin : gen_lane
            logic signed [2*W-1:0] prod;
            logic [ACC_W:0]        sum;

            if (gi == 0) begin : g_head
                assign op_in[gi]    = feed_op;
                assign vld_in[gi]   = feed_fire;
                assign first_in[gi] = feed_first;
                assign last_in[gi]  = feed_last;
            end else begin : g_body
                assign op_in[gi]    = op_reg[gi-1];
                assign vld_in[gi]   = vld_reg[gi-1];
                assign first_in[gi] = first_reg[gi-1];
                assign last_in[gi]  = last_reg[gi-1];
            end

            if (gi == N_MACS - 1) begin : g_htail
                assign h_next[gi] = '0;
            end else begin : g_hbody
                assign h_next[gi] = h_reg[gi+1];
            end

            assign prod = op_reg[gi] * w_reg[gi];
            // The first product of a pass replaces the old result
            assign sum  = (first_reg[gi] ? {(ACC_W+1){1'b0}} : {acc_reg[gi][ACC_W-1], acc_reg[gi]})
                        + {{(ACC_W+1-2*W){prod[2*W-1]}}, prod};

            // Weight latch at start; layer snapshot then shift toward slot 0
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w_reg[gi] <= '0;
                    h_reg[gi] <= '0;
                end else if (clear_all) begin
                    h_reg[gi] <= '0;
                end else if (start_acc) begin
                    w_reg[gi] <= w_in[gi*W +: W];
                    h_reg[gi] <= clamp_w(acc_reg[gi]);
                end else if (feed_fire && mode_reg) begin
                    h_reg[gi] <= h_next[gi];
                end
            end

            // Operand pipe slot: advances every cycle with its tag bits
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    op_reg[gi]    <= '0;
                    vld_reg[gi]   <= 1'b0;
                    first_reg[gi] <= 1'b0;
                    last_reg[gi]  <= 1'b0;
                end else if (clear_all) begin
                    op_reg[gi]    <= '0;
                    vld_reg[gi]   <= 1'b0;
                    first_reg[gi] <= 1'b0;
                    last_reg[gi]  <= 1'b0;
                end else begin
                    op_reg[gi]    <= op_in[gi];
                    vld_reg[gi]   <= vld_in[gi];
                    first_reg[gi] <= first_in[gi];
                    last_reg[gi]  <= last_in[gi];
                end
            end

            // Lane accumulator; valid pulses when the tagged last product lands
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg[gi]   <= '0;
                    valid_reg[gi] <= 1'b0;
                end else if (clear_all) begin
                    acc_reg[gi]   <= '0;
                    valid_reg[gi] <= 1'b0;
                end else begin
                    valid_reg[gi] <= vld_reg[gi] && last_reg[gi];
                    if (vld_reg[gi])
                        acc_reg[gi] <= sat_acc(sum);
                end
            end

            assign acc_out[gi*ACC_W +: ACC_W] = acc_reg[gi];
        end
    endgenerate

    assign valid_out = valid_reg;
    assign a_ready   = a_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
endmodule

// File: tb/tb_mac_layer_engine.sv
// Bench for mac_layer_engine (W=8, ACC_W=16, N_MACS=4). Expected lane
// results and done events are queued when a pass is issued. A negedge
// monitor pops and compares them whenever the DUT presents them.
module tb_mac_layer_engine;
    localparam int W = 8, ACC_W = 16, N = 4, K_MAX = 16, SAT = 1;

    logic          clk = 1'b0;
    logic          rst, start, mode, clear_all, a_valid;
    logic [4:0]    len;
    logic [7:0]    a_in;
    logic [31:0]   w_in;
    logic          a_ready, busy, done;
    logic [63:0]   acc_out;
    logic [3:0]    valid_out;

    typedef struct { int lane; logic [15:0] val; } exp_t;
    exp_t exp_q[$];
    bit   done_q[$];
    int   checks = 0;
    int   failures = 0;

    mac_layer_engine #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .K_MAX(K_MAX), .SAT(SAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
        .clear_all(clear_all), .a_in(a_in), .a_valid(a_valid), .a_ready(a_ready),
        .w_in(w_in), .busy(busy), .done(done), .acc_out(acc_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic push4(input int v0, input int v1, input int v2, input int v3);
        exp_q.push_back('{0, 16'(v0)});
        exp_q.push_back('{1, 16'(v1)});
        exp_q.push_back('{2, 16'(v2)});
        exp_q.push_back('{3, 16'(v3)});
    endtask

    // Monitor: every presented lane result and done pulse is matched to the queue
    always @(negedge clk) begin
        if (!rst) begin
            for (int ln = 0; ln < N; ln++) begin
                if (valid_out[ln]) begin
                    logic [15:0] got;
                    got = acc_out[ln*16 +: 16];
                    $display("result lane=%0d acc=%0d", ln, $signed(got));
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_result lane=%0d got=%0d exp=none", ln, $signed(got));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.lane != ln || got != e.val) begin
                            failures++;
                            $display("FAIL lane_result got lane=%0d val=%0d exp lane=%0d val=%0d",
                                     ln, $signed(got), e.lane, $signed(e.val));
                        end
                    end
                end
            end
            if (done) begin
                $display("done valid_out=%b", valid_out);
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done got=1 exp=0");
                end else begin
                    bit ev;
                    ev = done_q.pop_front();
                    if (valid_out[N-1] != ev) begin
                        failures++;
                        $display("FAIL done_align got=%0d exp=%0d", valid_out[N-1], ev);
                    end
                end
            end
        end
    end

    task automatic start_pass(input logic m, input logic [4:0] l, input logic [31:0] w);
        start = 1'b1; mode = m; len = l; w_in = w;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int v);
        int  n;
        bit  ok;
        a_in = v[7:0]; a_valid = 1'b1; n = 0; ok = 1'b0;
        while (!ok && n < 50) begin
            ok = a_ready;
            @(posedge clk); #1;
            n++;
        end
        a_valid = 1'b0;
        if (!ok) chk("feed_timeout", 0, 1);
    endtask

    task automatic wait_idle(output bit seen_ready);
        int n;
        seen_ready = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            seen_ready |= a_ready;
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        @(negedge clk); #1;
    endtask

    initial begin
        bit sr;
        int n;
        rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0; clear_all = 1'b0;
        a_in = '0; a_valid = 1'b0; w_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", acc_out, 0);
        chk("rst_flags", {a_ready, busy, done, valid_out}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single-sample LOAD
        push4(20, 30, 50, 70); done_q.push_back(1);
        start_pass(1'b0, 5'd1, pk(2, 3, 5, 7));
        chk("t1_a_ready_hi", a_ready, 1);
        feed(10);
        chk("t1_a_ready_lo", a_ready, 0);
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        chk("t1_done_latency", n, N);
        wait_idle(sr);
        chk("t1_acc", acc_out, {16'd70, 16'd50, 16'd30, 16'd20});

        // 2: LAYER chaining off the previous results
        push4(340, 510, 850, 1190); done_q.push_back(1);
        start_pass(1'b1, 5'd0, pk(2, 3, 5, 7));
        wait_idle(sr);
        chk("t2_a_ready_stays_low", sr, 0);

        // 3: four samples with a two-cycle a_valid gap
        push4(10, -10, 20, 0); done_q.push_back(1);
        start_pass(1'b0, 5'd4, pk(1, -1, 2, 0));
        feed(1); feed(2);
        repeat (2) begin @(posedge clk); #1; end
        feed(3); feed(4);
        wait_idle(sr);

        // 4: saturation on lane 0
        push4(SAT ? 32767 : -27436, 0, 0, 0); done_q.push_back(1);
        start_pass(1'b0, 5'd3, pk(127, 0, 0, 0));
        feed(100); feed(100); feed(100);
        wait_idle(sr);

        // 5a: clear_all mid-FEED aborts with no done
        start_pass(1'b0, 5'd4, pk(1, 1, 1, 1));
        feed(3); feed(4);
        chk("t5_busy_before_clear", busy, 1);
        clear_all = 1'b1;
        @(posedge clk); #1;
        clear_all = 1'b0;
        chk("t5_clear_acc", acc_out, 0);
        chk("t5_clear_flags", {busy, valid_out, a_ready}, 0);
        repeat (6) begin @(posedge clk); #1; end
        chk("t5_clear_acc_hold", acc_out, 0);

        // 5b: start during busy is ignored
        push4(11, 22, 33, 44); done_q.push_back(1);
        start_pass(1'b0, 5'd2, pk(1, 2, 3, 4));
        feed(5);
        start = 1'b1; mode = 1'b1; len = 5'd3; w_in = pk(9, 9, 9, 9);
        @(posedge clk); #1;
        start = 1'b0;
        feed(6);
        wait_idle(sr);

        // 5c: LOAD with len 0 pulses done only
        done_q.push_back(0);
        start_pass(1'b0, 5'd0, pk(1, 1, 1, 1));
        chk("t5_len0_busy", busy, 0);
        @(negedge clk); #1;
        chk("t5_len0_acc_hold", acc_out, {16'd44, 16'd33, 16'd22, 16'd11});
        chk("t5c_queues_empty", exp_q.size() + done_q.size(), 0);

        // 6: async reset while in DRAIN
        start_pass(1'b0, 5'd1, pk(2, 3, 5, 7));
        feed(10);
        chk("t6_busy_drain", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_acc", acc_out, 0);
        chk("t6_rst_flags", {a_ready, busy, done, valid_out}, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_after_rst_busy", busy, 0);
        repeat (6) begin @(posedge clk); #1; end
        chk("t6_after_rst_acc", acc_out, 0);

        chk("sb_empty", exp_q.size() + done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
